// File: rtl/c7b_pkg.sv
// Shared types and widths for the C7B instruction-cache unit.
package c7b_pkg;

    localparam int ICU_FETCH_W = 64;
    localparam int ICU_MEM_W   = 32;
    localparam int ICU_TAG_W   = 29;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        LO_W = 3'd2,
        HI   = 3'd3,
        HI_W = 3'd4,
        DONE = 3'd5
    } icu_state_t;

    // Tag of the 8-byte fetch bundle containing an address.
    function automatic logic [ICU_TAG_W-1:0] line_tag(input logic [31:0] addr);
        return addr[31:3];
    endfunction

endpackage

// File: rtl/c7bicu_lbuf.sv
// One-entry fetch line buffer: tag, valid and one 64-bit bundle.
module c7bicu_lbuf
    import c7b_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_inv,
    input  logic                   i_fill,
    input  logic [ICU_TAG_W-1:0]   i_fill_tag,
    input  logic [ICU_FETCH_W-1:0] i_fill_data,
    input  logic [ICU_TAG_W-1:0]   i_lookup_tag,
    output logic                   o_hit,
    output logic [ICU_FETCH_W-1:0] o_data
);

    logic                   r_valid;
    logic [ICU_TAG_W-1:0]   r_tag;
    logic [ICU_FETCH_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_inv) begin
            // An invalidate beats a fill arriving in the same cycle.
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_data  <= i_fill_data;
        end
    end

    assign o_hit  = r_valid & ~i_inv & (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule

// File: rtl/c7bicu.sv
// Instruction-cache unit: fetches an 8-byte bundle as two 32-bit memory beats.
// Define C7BICU_LINEBUF_EN to add a one-entry line buffer in front of memory.
module c7bicu
    import c7b_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ifu_icu_req_ic1,
    input  logic [31:0]            ifu_icu_addr_ic1,
    input  logic                   ifu_icu_cancel,
    input  logic                   ifu_icu_inv,
    output logic                   icu_ifu_ack_ic1,
    output logic                   icu_ifu_data_valid_ic2,
    output logic [ICU_FETCH_W-1:0] icu_ifu_data_ic2,
    output logic                   icu_mem_req,
    output logic [31:0]            icu_mem_addr,
    input  logic                   mem_icu_ack,
    input  logic                   mem_icu_rdata_valid,
    input  logic [ICU_MEM_W-1:0]   mem_icu_rdata
);

    icu_state_t             r_state;
    icu_state_t             w_state_next;
    logic                   r_kill;
    logic                   w_kill_next;
    logic [31:0]            r_base;
    logic [ICU_MEM_W-1:0]   r_lo;
    logic [ICU_MEM_W-1:0]   r_hi;
    logic [ICU_FETCH_W-1:0] r_data_hold;

    logic                   w_ack;
    logic                   w_hit;
    logic                   w_fill;
    logic                   w_kill_eff;
    logic                   w_data_valid;
    logic                   w_busy;
    logic [31:0]            w_addr_hi;
    logic [ICU_FETCH_W-1:0] w_assembled;
    logic [ICU_FETCH_W-1:0] w_buf_data;
    logic                   w_unused;

    assign w_ack      = ifu_icu_req_ic1 & (r_state == IDLE) & ~ifu_icu_cancel;
    assign w_kill_eff = r_kill | ifu_icu_cancel;
    assign w_busy     = (r_state == LO) | (r_state == LO_W) | (r_state == HI) | (r_state == HI_W);
    assign w_addr_hi  = r_base + 32'd4;

`ifdef C7BICU_LINEBUF_EN
    c7bicu_lbuf u_lbuf (
        .clk          (clk),
        .reset        (reset),
        .i_inv        (ifu_icu_inv),
        .i_fill       (w_fill),
        .i_fill_tag   (line_tag(r_base)),
        .i_fill_data  ({mem_icu_rdata, r_lo}),
        .i_lookup_tag (line_tag(ifu_icu_addr_ic1)),
        .o_hit        (w_hit),
        .o_data       (w_buf_data)
    );
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    assign w_unused = ^{ifu_icu_inv, ifu_icu_addr_ic1[2:0], w_fill};

    always_comb begin
        w_state_next = r_state;
        w_kill_next  = r_kill;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ack) begin
                    w_state_next = w_hit ? DONE : LO;
                end
            end
            LO: begin
                if (mem_icu_ack) begin
                    w_state_next = LO_W;
                end
            end
            LO_W: begin
                // A killed low beat never launches the high beat.
                if (mem_icu_rdata_valid) begin
                    w_state_next = w_kill_eff ? IDLE : HI;
                end
            end
            HI: begin
                if (mem_icu_ack) begin
                    w_state_next = HI_W;
                end
            end
            HI_W: begin
                if (mem_icu_rdata_valid) begin
                    if (w_kill_eff) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DONE;
                        w_fill       = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (ifu_icu_cancel && w_busy) begin
            w_kill_next = 1'b1;
        end
        if (w_state_next == IDLE) begin
            w_kill_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_base      <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_data_hold <= '0;
        end else begin
            r_state <= w_state_next;
            r_kill  <= w_kill_next;
            if (w_ack) begin
                r_base <= {ifu_icu_addr_ic1[31:3], 3'b000};
            end
            if (w_ack && w_hit) begin
                r_lo <= w_buf_data[ICU_MEM_W-1:0];
                r_hi <= w_buf_data[ICU_FETCH_W-1:ICU_MEM_W];
            end
            if ((r_state == LO_W) && mem_icu_rdata_valid) begin
                r_lo <= mem_icu_rdata;
            end
            if ((r_state == HI_W) && mem_icu_rdata_valid) begin
                r_hi <= mem_icu_rdata;
            end
            if (w_data_valid) begin
                r_data_hold <= w_assembled;
            end
        end
    end

    assign w_assembled  = {r_hi, r_lo};
    assign w_data_valid = (r_state == DONE) & ~r_kill & ~ifu_icu_cancel;

    // The bundle output only moves while valid, so the IFU sees a stable value otherwise.
    assign icu_ifu_ack_ic1        = w_ack;
    assign icu_ifu_data_valid_ic2 = w_data_valid;
    assign icu_ifu_data_ic2       = w_data_valid ? w_assembled : r_data_hold;
    assign icu_mem_req            = (r_state == LO) | (r_state == HI);
    assign icu_mem_addr           = ((r_state == HI) | (r_state == HI_W)) ? w_addr_hi : r_base;

endmodule

// File: tb/tb_c7bicu.sv
// Self-checking bench for c7bicu: directed and randomized fetches against a memory model.
module tb_c7bicu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic        cancel;
    logic        inv;
    logic        ack_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        rvalid;
    logic [31:0] rdata;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [63:0] last_data = '0;
    bit          buf_valid = 1'b0;
    logic [28:0] buf_tag   = '0;
    logic [31:0] salt;
    logic [31:0] mem_init [logic [31:0]];

    always #5 clk = ~clk;

    c7bicu dut (
        .clk                    (clk),
        .reset                  (reset),
        .ifu_icu_req_ic1        (req),
        .ifu_icu_addr_ic1       (addr),
        .ifu_icu_cancel         (cancel),
        .ifu_icu_inv            (inv),
        .icu_ifu_ack_ic1        (ack_o),
        .icu_ifu_data_valid_ic2 (valid_o),
        .icu_ifu_data_ic2       (data_o),
        .icu_mem_req            (mem_req),
        .icu_mem_addr           (mem_addr),
        .mem_icu_ack            (mem_ack),
        .mem_icu_rdata_valid    (rvalid),
        .mem_icu_rdata          (rdata)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 0; cancel = 0; inv = 0; mem_ack = 0; rvalid = 0;
            #1;
            chk({tag, "_memreq"}, {63'd0, mem_req}, 64'd0);
            chk({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
            chk({tag, "_hold"}, data_o, last_data);
        end
    endtask

    // cancel_ph: -1 none, 0 LO, 1 LO_W, 2 HI, 3 HI_W, 4 DONE (asserted on first cycle of that phase)
    task automatic fetch(input logic [31:0] a, input int ack_dly, input int rd_dly, input int cancel_ph);
        logic [31:0] base;
        logic [31:0] ea;
        logic [63:0] exp_data;
        bit          killed;
        bit          hit;
        bit          c;
        bit          exp_valid;
        base     = {a[31:3], 3'b000};
        exp_data = {mem_fn(base + 32'd4), mem_fn(base)};
        killed   = 0;
`ifdef C7BICU_LINEBUF_EN
        hit = buf_valid && (buf_tag == a[31:3]);
`else
        hit = 0;
`endif
        @(negedge clk);
        req = 1; addr = a; cancel = 0; mem_ack = 0; rvalid = 0;
        #1;
        chk("ack", {63'd0, ack_o}, 64'd1);
        if (!hit) begin
            for (int b = 0; b < 2; b++) begin
                if (!killed) begin
                    ea = base + 32'(4 * b);
                    for (int i = 0; i <= ack_dly; i++) begin
                        @(negedge clk);
                        req = 0;
                        c = (cancel_ph == 2 * b) && (i == 0);
                        cancel = c; rvalid = 0; mem_ack = (i == ack_dly);
                        #1;
                        chk("memreq_held", {63'd0, mem_req}, 64'd1);
                        chk("memaddr", {32'd0, mem_addr}, {32'd0, ea});
                        chk("no_valid_req", {63'd0, valid_o}, 64'd0);
                        if (c) killed = 1;
                    end
                    for (int i = 1; i <= rd_dly; i++) begin
                        @(negedge clk);
                        c = (cancel_ph == 2 * b + 1) && (i == 1);
                        cancel = c; mem_ack = 0; rvalid = (i == rd_dly); rdata = mem_fn(ea);
                        #1;
                        chk("memreq_wait", {63'd0, mem_req}, 64'd0);
                        chk("no_valid_wait", {63'd0, valid_o}, 64'd0);
                        if (c) killed = 1;
                    end
                end
            end
        end
        @(negedge clk);
        req = 0; mem_ack = 0; rvalid = 0;
        cancel = (cancel_ph == 4);
        #1;
        exp_valid = !killed && (cancel_ph != 4);
        chk("valid", {63'd0, valid_o}, {63'd0, exp_valid});
        chk("memreq_done", {63'd0, mem_req}, 64'd0);
        if (exp_valid) begin
            chk("data", data_o, exp_data);
            last_data = exp_data;
        end else begin
            chk("data_hold_nv", data_o, last_data);
        end
        if (!hit && !killed) begin
            buf_valid = 1;
            buf_tag   = a[31:3];
        end
        $display("fetch addr=%h ack_dly=%0d rd_dly=%0d cancel_ph=%0d hit=%0d valid=%0d data=%h",
                 a, ack_dly, rd_dly, cancel_ph, hit, valid_o, data_o);
        quiet(1, "post");
    endtask

    task automatic do_inv();
        @(negedge clk);
        inv = 1; req = 0; cancel = 0;
        @(negedge clk);
        inv = 0;
        buf_valid = 0;
        $display("invalidate");
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] prev_a;
        int          ph;
        salt = $urandom;
        mem_init[32'h1c00_0000] = 32'h1111_1111;
        mem_init[32'h1c00_0004] = 32'h2222_2222;
        reset = 1; req = 0; addr = 0; cancel = 0; inv = 0;
        mem_ack = 0; rvalid = 0; rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ack", {63'd0, ack_o}, 64'd0);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_memreq", {63'd0, mem_req}, 64'd0);
        chk("rst_memaddr", {32'd0, mem_addr}, 64'd0);
        chk("rst_data", data_o, 64'd0);
        reset = 0;
        $display("reset released");

        // Basic fetch, wraparound fetch and the zero base after it.
        fetch(32'h1c00_0004, 1, 2, -1);
        fetch(32'hffff_fff8, 0, 1, -1);
        fetch(32'h0000_0003, 2, 1, -1);

        // Cancel during LO_W: low beat completes, no high beat, then a fresh request.
        fetch(32'h2000_0010, 0, 2, 1);
        quiet(2, "kill_idle");
        fetch(32'h2000_0018, 1, 1, -1);

        // Cancel with request in IDLE.
        @(negedge clk);
        req = 1; cancel = 1; addr = 32'h3000_0000;
        #1;
        chk("cancel_req_ack", {63'd0, ack_o}, 64'd0);
        $display("cancel+req in idle ack=%0d", ack_o);
        quiet(2, "cancel_req");

        // Memory ack held off for five cycles.
        fetch(32'h4000_0020, 5, 2, -1);

        // Cancels in the other phases.
        fetch(32'h5000_0000, 2, 1, 0);
        fetch(32'h5000_0008, 1, 2, 2);
        fetch(32'h5000_0010, 1, 2, 3);
        fetch(32'h5000_0018, 0, 1, 4);

        // Line buffer: repeat fetch hits (when enabled), invalidate forces memory.
        fetch(32'h1c00_0000, 1, 2, -1);
        fetch(32'h1c00_0000, 1, 2, -1);
        do_inv();
        fetch(32'h1c00_0000, 1, 2, -1);

        // Randomized fetches.
        prev_a = 32'h1c00_0000;
        for (int n = 0; n < 30; n++) begin
            a  = ($urandom_range(0, 2) == 0) ? prev_a : $urandom;
            ph = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            fetch(a, $urandom_range(0, 3), $urandom_range(1, 3), ph);
            if ($urandom_range(0, 7) == 0) do_inv();
            prev_a = a;
        end

        // Reset while waiting for the high beat; late read data must be ignored.
        @(negedge clk);
        req = 1; addr = 32'h6000_0008;
        #1;
        chk("r42_ack", {63'd0, ack_o}, 64'd1);
        @(negedge clk);
        req = 0; mem_ack = 1;
        @(negedge clk);
        mem_ack = 0; rvalid = 1; rdata = 32'hdead_beef;
        @(negedge clk);
        rvalid = 0; mem_ack = 1;
        #1;
        chk("r42_hi_addr", {32'd0, mem_addr}, 64'h6000_000c);
        @(negedge clk);
        mem_ack = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        chk("r42_ack0", {63'd0, ack_o}, 64'd0);
        chk("r42_valid", {63'd0, valid_o}, 64'd0);
        chk("r42_memreq", {63'd0, mem_req}, 64'd0);
        chk("r42_memaddr", {32'd0, mem_addr}, 64'd0);
        chk("r42_data", data_o, 64'd0);
        $display("reset in HI_W: memreq=%0d valid=%0d data=%h", mem_req, valid_o, data_o);
        last_data = '0;
        buf_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rvalid = 1; rdata = $urandom;
            #1;
            chk("stray_memreq", {63'd0, mem_req}, 64'd0);
            chk("stray_valid", {63'd0, valid_o}, 64'd0);
            chk("stray_data", data_o, 64'd0);
        end
        @(negedge clk);
        rvalid = 0;
        fetch(32'h7000_0000, 1, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
